playfield_clear_buffer: RTL and testbench

- Parametrised successor to the fixed 20x10x4 playfield row store.
- Holds a ROWS x COLS grid of PIX_W-bit cells and accepts a whole-map load.
- Contains an autonomous line-clear engine. The engine finds every full row and collapses the stack downward, one row examined per cycle.
- Reports the number of rows cleared, so the game controller no longer issues per-row load strobes.

---
 rtl/playfield_clear_buffer.sv | 92 +++++++++
 tb/tb_playfield_clear_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_clear_buffer.sv
// Playfield grid store with a self-running line-clear engine: examines one row
// per cycle from the bottom up and collapses full rows downward.
module playfield_clear_buffer #(
  parameter int ROWS  = 20,
  parameter int COLS  = 10,
  parameter int PIX_W = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          LoadAll,
  input  logic [ROWS*COLS*PIX_W-1:0]    PixelMapIn,
  input  logic                          ClearStart,
  output logic                          Busy,
  output logic                          Done,
  output logic [$clog2(ROWS+1)-1:0]     LinesCleared,
  output logic [ROWS-1:0]               FullMask,
  output logic [ROWS*COLS*PIX_W-1:0]    PixelMapOut
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(ROWS + 1);

  typedef logic [COLS-1:0][PIX_W-1:0] row_t;
  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  state_t            state, state_nxt;
  row_t [ROWS-1:0]   grid;
  logic [RW-1:0]     row_ptr;
  logic [CW-1:0]     lines_cleared;

  always_comb begin
    FullMask = '1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (grid[r][c] == '0) FullMask[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ClearStart && !LoadAll) state_nxt = SCAN;
      SCAN:    if (!FullMask[row_ptr] && row_ptr == '0) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      grid          <= '0;
      row_ptr       <= RW'(ROWS - 1);
      lines_cleared <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (LoadAll) begin
            grid <= PixelMapIn;
          end else if (ClearStart) begin
            lines_cleared <= '0;
            row_ptr       <= RW'(ROWS - 1);
          end
        end
        SCAN: begin
          if (FullMask[row_ptr]) begin
            // Pointer holds so the row shifted down into it is re-examined.
            for (int unsigned i = 1; i < ROWS; i++) begin
              if (RW'(i) <= row_ptr) grid[i] <= grid[i-1];
            end
            grid[0]       <= '0;
            lines_cleared <= lines_cleared + 1'b1;
          end else if (row_ptr != '0) begin
            row_ptr <= row_ptr - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy         = (state == SCAN);
  assign Done         = (state == FINISH);
  assign LinesCleared = lines_cleared;
  assign PixelMapOut  = grid;

endmodule

// File: tb/tb_playfield_clear_buffer.sv
// Directed bench for playfield_clear_buffer: loads, clear passes, ignored
// inputs during a pass, mid-pass reset and simultaneous load/start.
module tb_playfield_clear_buffer;

  localparam int ROWS  = 20;
  localparam int COLS  = 10;
  localparam int PIX_W = 4;
  localparam int CW    = $clog2(ROWS + 1);
  localparam int WIN   = 70;

  typedef logic [ROWS-1:0][COLS-1:0][PIX_W-1:0] map_t;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          LoadAll;
  map_t          PixelMapIn;
  logic          ClearStart;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] LinesCleared;
  logic [ROWS-1:0] FullMask;
  map_t          PixelMapOut;

  int vec  = 0;
  int errs = 0;

  playfield_clear_buffer #(.ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .LoadAll      (LoadAll),
    .PixelMapIn   (PixelMapIn),
    .ClearStart   (ClearStart),
    .Busy         (Busy),
    .Done         (Done),
    .LinesCleared (LinesCleared),
    .FullMask     (FullMask),
    .PixelMapOut  (PixelMapOut)
  );

  always #5 Clk = ~Clk;

  task automatic load_map(input map_t m);
    @(negedge Clk);
    LoadAll    = 1'b1;
    PixelMapIn = m;
    @(negedge Clk);
    LoadAll    = 1'b0;
    PixelMapIn = '0;
  endtask

  // Start a pass and watch a fixed window; optionally disturb the inputs once.
  task automatic run_clear(input int disturb_at, output int busy_n, output int done_n,
                           output logic [CW-1:0] lc, output int overlap_n);
    map_t sevens;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) sevens[r][c] = 4'h7;
    busy_n = 0; done_n = 0; overlap_n = 0; lc = '1;
    @(negedge Clk);
    ClearStart = 1'b1;
    @(negedge Clk);
    ClearStart = 1'b0;
    for (int cyc = 0; cyc < WIN; cyc++) begin
      LoadAll    = 1'b0;
      ClearStart = 1'b0;
      PixelMapIn = '0;
      if (Busy) busy_n++;
      if (Busy && Done) overlap_n++;
      if (Done) begin
        done_n++;
        lc = LinesCleared;
      end
      if (cyc == disturb_at) begin
        LoadAll    = 1'b1;
        ClearStart = 1'b1;
        PixelMapIn = sevens;
      end
      @(negedge Clk);
    end
  endtask

  task automatic check_pass(input string name, input int busy_n, input int done_n,
                            input logic [CW-1:0] lc, input int overlap_n,
                            input int exp_busy, input logic [CW-1:0] exp_lc, input map_t exp_map);
    vec++;
    if (done_n !== 1) begin
      errs++; $display("FAIL %s done_count got %0d want 1", name, done_n);
    end
    vec++;
    if (busy_n !== exp_busy) begin
      errs++; $display("FAIL %s busy_cycles got %0d want %0d", name, busy_n, exp_busy);
    end
    vec++;
    if (lc !== exp_lc) begin
      errs++; $display("FAIL %s lines_cleared got %0d want %0d", name, lc, exp_lc);
    end
    vec++;
    if (overlap_n !== 0) begin
      errs++; $display("FAIL %s busy_done_overlap got %0d want 0", name, overlap_n);
    end
    vec++;
    if (LinesCleared !== exp_lc) begin
      errs++; $display("FAIL %s lines_cleared_held got %0d want %0d", name, LinesCleared, exp_lc);
    end
    vec++;
    if (PixelMapOut !== exp_map) begin
      errs++; $display("FAIL %s grid got %h want %h", name, PixelMapOut, exp_map);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; LoadAll = 1'b0; ClearStart = 1'b0; PixelMapIn = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    vec++; if (PixelMapOut !== '0) begin errs++; $display("FAIL reset_grid got %h want 0", PixelMapOut); end
    vec++; if (Busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", Busy); end
    vec++; if (Done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", Done); end
    vec++; if (LinesCleared !== '0) begin errs++; $display("FAIL reset_lc got %0d want 0", LinesCleared); end
    vec++; if (FullMask !== '0) begin errs++; $display("FAIL reset_fullmask got %h want 0", FullMask); end
  endtask

  task automatic test_single_clear;
    map_t m, e;
    int b, d, o;
    logic [CW-1:0] lc;
    m = '0;
    for (int c = 0; c < COLS; c++) m[19][c] = 4'h1;
    m[18][0] = 4'h2;
    load_map(m);
    vec++; if (PixelMapOut !== m) begin errs++; $display("FAIL single_load got %h want %h", PixelMapOut, m); end
    vec++; if (FullMask !== 20'h80000) begin errs++; $display("FAIL single_fullmask got %h want 80000", FullMask); end
    run_clear(-1, b, d, lc, o);
    e = '0;
    e[19][0] = 4'h2;
    check_pass("single", b, d, lc, o, 21, CW'(1), e);
  endtask

  task automatic test_double_clear;
    map_t m, e;
    int b, d, o;
    logic [CW-1:0] lc;
    m = '0;
    for (int c = 0; c < COLS; c++) begin
      m[16][c] = 4'hF;
      m[18][c] = 4'hF;
    end
    m[17][3] = 4'h3;
    m[15][5] = 4'h5;
    load_map(m);
    vec++; if (FullMask !== 20'h50000) begin errs++; $display("FAIL double_fullmask got %h want 50000", FullMask); end
    run_clear(-1, b, d, lc, o);
    // Empty row 19 sits below both cleared rows and is left in place.
    e = '0;
    e[18][3] = 4'h3;
    e[17][5] = 4'h5;
    check_pass("double", b, d, lc, o, 22, CW'(2), e);
  endtask

  task automatic test_all_full;
    map_t m;
    int b, d, o;
    logic [CW-1:0] lc;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r][c] = 4'hF;
    load_map(m);
    vec++; if (FullMask !== '1) begin errs++; $display("FAIL allfull_fullmask got %h want fffff", FullMask); end
    run_clear(-1, b, d, lc, o);
    check_pass("all_full", b, d, lc, o, 40, CW'(20), '0);
  endtask

  task automatic test_no_full;
    map_t m;
    int b, d, o;
    logic [CW-1:0] lc;
    m = '0;
    m[0][9] = 4'h4;
    m[12][2] = 4'h8;
    load_map(m);
    run_clear(-1, b, d, lc, o);
    check_pass("no_full", b, d, lc, o, 20, CW'(0), m);
  endtask

  task automatic test_ignore_during_scan;
    map_t m, e;
    int b, d, o;
    logic [CW-1:0] lc;
    m = '0;
    for (int c = 0; c < COLS; c++) m[19][c] = 4'h1;
    m[18][0] = 4'h2;
    load_map(m);
    run_clear(3, b, d, lc, o);
    e = '0;
    e[19][0] = 4'h2;
    check_pass("ignore", b, d, lc, o, 21, CW'(1), e);
  endtask

  task automatic test_reset_mid_pass;
    map_t m;
    int done_n;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r][c] = 4'hF;
    load_map(m);
    @(negedge Clk);
    ClearStart = 1'b1;
    @(negedge Clk);
    ClearStart = 1'b0;
    repeat (5) @(negedge Clk);
    vec++; if (Busy !== 1'b1) begin errs++; $display("FAIL midreset_busy_before got %b want 1", Busy); end
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    vec++; if (Busy !== 1'b0) begin errs++; $display("FAIL midreset_busy got %b want 0", Busy); end
    vec++; if (PixelMapOut !== '0) begin errs++; $display("FAIL midreset_grid got %h want 0", PixelMapOut); end
    vec++; if (LinesCleared !== '0) begin errs++; $display("FAIL midreset_lc got %0d want 0", LinesCleared); end
    @(negedge Clk);
    Reset = 1'b0;
    done_n = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (Done) done_n++;
      @(negedge Clk);
    end
    vec++; if (done_n !== 0) begin errs++; $display("FAIL midreset_done got %0d want 0", done_n); end
  endtask

  task automatic test_load_and_start;
    map_t m;
    int busy_n;
    m = '0;
    m[4][4] = 4'h9;
    for (int c = 0; c < COLS; c++) m[10][c] = 4'h6;
    @(negedge Clk);
    LoadAll    = 1'b1;
    ClearStart = 1'b1;
    PixelMapIn = m;
    @(negedge Clk);
    LoadAll    = 1'b0;
    ClearStart = 1'b0;
    PixelMapIn = '0;
    vec++; if (PixelMapOut !== m) begin errs++; $display("FAIL loadstart_grid got %h want %h", PixelMapOut, m); end
    busy_n = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (Busy || Done) busy_n++;
      @(negedge Clk);
    end
    vec++; if (busy_n !== 0) begin errs++; $display("FAIL loadstart_busy got %0d want 0", busy_n); end
    vec++; if (PixelMapOut !== m) begin errs++; $display("FAIL loadstart_grid_after got %h want %h", PixelMapOut, m); end
  endtask

  initial begin
    test_reset();
    test_single_clear();
    test_double_clear();
    test_all_full();
    test_no_full();
    test_ignore_during_scan();
    test_reset_mid_pass();
    test_load_and_start();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
